// File: rtl/apb_slave_mem_pkg.sv
// apb_slv_pkg: shared types and defaults for the APB3 register-file completer.
// Exports state_t (IDLE/WAIT/RESP), default bus widths/depth and counter width.
package apb_slv_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 256;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB3 bus bundle between one master and one completer.
// master drives PSEL/PENABLE/PWRITE/PADDR/PWDATA; slave drives PREADY/PRDATA/PSLVERR.
interface apb_slave_mem_if
  import apb_slv_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_slave_mem_mem.sv
// apb_slv_mem: DEPTH x DATA_W storage, sync write, sync clear, async read.
// Ports: clk, clr_n (sync clear), we/waddr/wdata, raddr -> rdata.
module apb_slv_mem
  import apb_slv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer over a byte register file, registered responses.
// Ports: PCLK, PRESETn (sync, active-low), bus (slave modport). Macro APB_SLV_WAIT_EN adds wait states.
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic PCLK,
  input  logic PRESETn,
  apb_slave_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_err;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] resp_data;
  logic              we;

`ifdef APB_SLV_WAIT_EN
  localparam logic [CNT_W-1:0] WAIT_N = CNT_W'(WAIT_CYCLES);
  logic [CNT_W-1:0] cnt;
`endif

  // With zero waits the response is built from the live setup,
  // otherwise from the latched copy.
  always_comb begin
    cur_write = lat_write;
    cur_addr  = lat_addr;
    if (state == IDLE) begin
      cur_write = bus.PWRITE;
      cur_addr  = bus.PADDR;
    end
    cur_err   = {1'b0, cur_addr} >= DEPTH_L;
    resp_data = (cur_write || cur_err) ? '0 : rd_data;
  end

  // pslverr still holds this transfer's error flag during RESP.
  assign we = (state == RESP) && bus.PSEL && bus.PENABLE &&
              lat_write && !pslverr;

  apb_slv_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (PCLK),
    .clr_n(PRESETn),
    .we   (we),
    .waddr(lat_addr[AW-1:0]),
    .wdata(lat_wdata),
    .raddr(cur_addr[AW-1:0]),
    .rdata(rd_data)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
`ifdef APB_SLV_WAIT_EN
      cnt       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            lat_write <= bus.PWRITE;
            lat_addr  <= bus.PADDR;
            lat_wdata <= bus.PWDATA;
`ifdef APB_SLV_WAIT_EN
            if (WAIT_N == '0) begin
              state   <= RESP;
              pready  <= 1'b1;
              prdata  <= resp_data;
              pslverr <= cur_err;
            end else begin
              state   <= WAIT;
              cnt     <= WAIT_N - 1'b1;
            end
`else
            state   <= RESP;
            pready  <= 1'b1;
            prdata  <= resp_data;
            pslverr <= cur_err;
`endif
          end
        end
`ifdef APB_SLV_WAIT_EN
        WAIT: begin
          if (!bus.PSEL) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state   <= RESP;
            pready  <= 1'b1;
            prdata  <= resp_data;
            pslverr <= cur_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        RESP: begin
          state   <= IDLE;
          pready  <= 1'b0;
          prdata  <= '0;
          pslverr <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          pready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PREADY  = pready;
  assign bus.PRDATA  = prdata;
  assign bus.PSLVERR = pslverr;

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB3 completer (slave) that answers the transfers our APB master issues. It holds a byte-wide register file. Per access it returns PREADY, PRDATA and PSLVERR. It sits on the far side of the APB bus from the master. It is the DUT endpoint for the master-side read-data and error paths.

Parameters:
ADDR_W, 9, PADDR width.
DATA_W, 8, PWDATA/PRDATA width.
DEPTH, 256, number of storage locations; legal address range is 0..DEPTH-1.
WAIT_CYCLES, 2, number of ACCESS-phase wait states; used only when APB_SLV_WAIT_EN is defined; range 0..15.

Ports:
PCLK  in  1  single clock; all logic samples on the rising edge.
PRESETn  in  1  reset; synchronous, active-low.
PSEL  in  1  slave select.
PENABLE  in  1  access-phase indicator.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  ADDR_W  byte address.
PWDATA  in  DATA_W  write data.
PREADY  out  1  transfer-complete strobe, registered.
PRDATA  out  DATA_W  read data, registered; valid only while PREADY=1.
PSLVERR  out  1  error response, registered; valid only while PREADY=1.

Behaviour:
- Reset (PRESETn=0 sampled at an edge):
  - PREADY=0, PRDATA=0, PSLVERR=0, FSM=IDLE, wait counter=0.
  - All DEPTH storage locations cleared to 0.
  - Reset asserted mid-transfer aborts the transfer; no write commits.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Setup sampled (PSEL=1, PENABLE=0) -> latch PWRITE, PADDR, PWDATA.
  - If effective wait count W=0 -> RESP. Otherwise -> WAIT with counter=W-1.
- WAIT:
  - Counter decrements each edge while PSEL=1.
  - When counter=0 -> RESP.
- RESP:
  - PREADY=1 for exactly one cycle, together with PRDATA and PSLVERR.
  - Next edge -> IDLE and PREADY=0.
- Latency: setup sampled at edge T; PREADY high during cycle T+1+W; transfer completes at edge T+1+W.
  - W=0 gives the minimum 2-cycle APB transfer.
- Write:
  - Commits at the completion edge (PSEL=PENABLE=PREADY=1), using the latched address and data.
  - PRDATA=0 on write responses.
- Read:
  - PRDATA = mem[latched PADDR], registered when entering RESP.
- Error:
  - Latched PADDR >= DEPTH -> PSLVERR=1 with PREADY. No write. PRDATA=0.
  - PADDR bits above the range needed for DEPTH are decoded in this check; no aliasing.
  - PADDR=DEPTH-1 is legal.
- Abort: PSEL=0 sampled in WAIT or RESP -> IDLE at that edge. PREADY=0 next cycle. No write.
- Back-to-back transfers:
  - A new setup may be sampled at the edge immediately after completion; it is accepted from IDLE.
  - A setup is never lost.
- Setup/data stability: PADDR/PWDATA changes during WAIT are ignored; latched values are used.
- Protocol violation:
  - PSEL=1 with PENABLE=1 sampled in IDLE (no prior setup) -> ignored; stay IDLE, PREADY=0.

Optional Feature:
APB_SLV_WAIT_EN
- Defined: W = WAIT_CYCLES; the wait counter and WAIT state are compiled in.
- Not defined: W = 0; WAIT state and counter are removed; every transfer completes in 2 cycles; the WAIT_CYCLES parameter is ignored.

Decomposition:
- Package apb_slv_pkg:
  - State enum typedef (IDLE, WAIT, RESP).
  - Default ADDR_W/DATA_W/DEPTH localparams.
  - Counter width constant (4 bits).
- Sub-module apb_slv_mem:
  - DEPTH x DATA_W storage array.
  - Synchronous write-enable and synchronous clear.
  - Combinational read port.
  - Instantiated once by apb_slave_mem.

Test Plan:
- Reset: PRESETn=0 for 2 cycles, then read addr 0x05 -> PRDATA=0x00, PSLVERR=0, PREADY exactly one cycle.
- Write then read:
  - Write 0xA5 to 0x010, then read 0x010 -> PRDATA=0xA5.
  - Without macro: PREADY in the 2nd cycle of each transfer.
  - With macro and WAIT_CYCLES=2: PREADY in the 4th cycle.
- Boundary address:
  - Write 0x3C to 0x0FF, read back -> 0x3C, PSLVERR=0.
  - Write 0x77 to 0x100 -> PSLVERR=1, PREADY=1. Read 0x100 -> PRDATA=0x00, PSLVERR=1. Location 0x000 unchanged.
- Back-to-back: write 0x11@0x001, 0x22@0x002, 0x33@0x003 with no idle cycles, then read each -> 0x11, 0x22, 0x33; no setup dropped.
- Abort:
  - Macro on, WAIT_CYCLES=3; write 0x99@0x020; drop PSEL in the 2nd WAIT cycle.
  - Expect PREADY never asserts; FSM returns to IDLE.
  - Subsequent read 0x020 -> 0x00.
- Mid-op reset: PRESETn=0 during the access phase of write 0x55@0x030 -> PREADY=0 next cycle; read 0x030 after release -> 0x00.
